// File: rtl/usb_kbd_buffer_pkg.sv
// rtl/usb_kbd_buffer_pkg.sv - HID constants, register map and scancode translation
package usb_hid_pkg;

    localparam logic [7:0] SHIFT_MASK = 8'h22;
    localparam logic [7:0] CTRL_MASK  = 8'h11;

    localparam logic [1:0] TYP_NONE  = 2'd0;
    localparam logic [1:0] TYP_KBD   = 2'd1;
    localparam logic [1:0] TYP_MOUSE = 2'd2;
    localparam logic [1:0] TYP_PAD   = 2'd3;

    localparam logic [7:0] REG_STATUS = 8'h00;
    localparam logic [7:0] REG_CHAR   = 8'h01;
    localparam logic [7:0] REG_MOD    = 8'h02;
    localparam logic [7:0] REG_COUNT  = 8'h03;
    localparam logic [7:0] REG_CTRL   = 8'h04;
    localparam logic [7:0] REG_DROPS  = 8'h05;

    localparam int CTRL_REPEN    = 0;
    localparam int CTRL_FLUSH    = 1;
    localparam int CTRL_CLR_OVF  = 2;
    localparam int CTRL_CLR_DROP = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_COMMIT
    } scan_state_t;

    // US layout; ctrl folds letters onto 0x01..0x1a, zero means "no character"
    function automatic logic [7:0] scancode2char(input logic [7:0] code, input logic [7:0] mods);
        logic       shift;
        logic       ctrl;
        logic [7:0] c;
        shift = |(mods & SHIFT_MASK);
        ctrl  = |(mods & CTRL_MASK);
        c     = 8'h00;
        if (code >= 8'h04 && code <= 8'h1d) begin
            c = (shift ? 8'h41 : 8'h61) + (code - 8'h04);
            if (ctrl) c = c & 8'h1f;
        end else begin
            case (code)
                8'h1e: c = shift ? 8'h21 : 8'h31;
                8'h1f: c = shift ? 8'h40 : 8'h32;
                8'h20: c = shift ? 8'h23 : 8'h33;
                8'h21: c = shift ? 8'h24 : 8'h34;
                8'h22: c = shift ? 8'h25 : 8'h35;
                8'h23: c = shift ? 8'h5e : 8'h36;
                8'h24: c = shift ? 8'h26 : 8'h37;
                8'h25: c = shift ? 8'h2a : 8'h38;
                8'h26: c = shift ? 8'h28 : 8'h39;
                8'h27: c = shift ? 8'h29 : 8'h30;
                8'h28: c = 8'h0d;
                8'h29: c = 8'h1b;
                8'h2a: c = 8'h08;
                8'h2b: c = 8'h09;
                8'h2c: c = 8'h20;
                8'h2d: c = shift ? 8'h5f : 8'h2d;
                8'h2e: c = shift ? 8'h2b : 8'h3d;
                8'h2f: c = shift ? 8'h7b : 8'h5b;
                8'h30: c = shift ? 8'h7d : 8'h5d;
                8'h31: c = shift ? 8'h7c : 8'h5c;
                8'h33: c = shift ? 8'h3a : 8'h3b;
                8'h34: c = shift ? 8'h22 : 8'h27;
                8'h35: c = shift ? 8'h7e : 8'h60;
                8'h36: c = shift ? 8'h3c : 8'h2c;
                8'h37: c = shift ? 8'h3e : 8'h2e;
                8'h38: c = shift ? 8'h3f : 8'h2f;
                default: c = 8'h00;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_kbd_buffer_if.sv
// rtl/usb_kbd_buffer_if.sv - HID report input and CPU register window bundle
interface usb_kbd_buffer_if #(
    parameter int NKEYS = 6
);
    logic                 report_i;
    logic [1:0]           typ_i;
    logic [7:0]           key_modifiers_i;
    logic [8*NKEYS-1:0]   keys_i;
    logic                 usb_cs;
    logic                 R_W_n;
    logic [7:0]           reg_addr_i;
    logic [7:0]           data_i;
    logic [7:0]           data_o;

    modport master (
        output report_i, typ_i, key_modifiers_i, keys_i,
        output usb_cs, R_W_n, reg_addr_i, data_i,
        input  data_o
    );

    modport slave (
        input  report_i, typ_i, key_modifiers_i, keys_i,
        input  usb_cs, R_W_n, reg_addr_i, data_i,
        output data_o
    );
endinterface

// File: rtl/usb_kbd_buffer_fifo.sv
// rtl/usb_kbd_buffer_fifo.sv - 16-bit keystroke FIFO with registered head entry
module usb_kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [15:0]   wdata,
    output logic [15:0]   head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf_set
);
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A pop on a full FIFO frees the slot the simultaneous push lands in
    assign do_pop     = pop & ~empty & ~flush;
    assign do_push    = push & ~flush & (~full | do_pop);
    assign ovf_set    = push & ~flush & full & ~do_pop;
    assign rd_ptr_nxt = flush ? '0 : rd_ptr + AW'(do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            if (flush) begin
                wr_ptr <= '0;
                count  <= '0;
                head   <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
                // The entry being written becomes head when it lands at the new read pointer
                if (do_push && wr_ptr == rd_ptr_nxt) head <= wdata;
                else                                 head <= mem[rd_ptr_nxt];
            end
        end
    end
endmodule

// File: rtl/usb_kbd_buffer.sv
// rtl/usb_kbd_buffer.sv - HID keyboard report scanner, auto-repeat and CPU register window
module usb_kbd_buffer
    import usb_hid_pkg::*;
#(
    parameter int NKEYS        = 6,
    parameter int DEPTH        = 8,
    parameter int CLK_HZ       = 25000000,
    parameter int REP_DELAY_MS = 500,
    parameter int REP_RATE_MS  = 33
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    usb_kbd_buffer_if.slave    bus
);
    localparam int     AW       = $clog2(DEPTH);
    localparam int     SW       = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam longint DLY_CYC  = longint'(REP_DELAY_MS) * longint'(CLK_HZ) / 1000;
    localparam longint RATE_CYC = longint'(REP_RATE_MS) * longint'(CLK_HZ) / 1000;
    localparam longint MAX_CYC  = (DLY_CYC > RATE_CYC) ? DLY_CYC : RATE_CYC;
    localparam int     TW       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    // Loaded one short so a fire at zero lands exactly DLY/RATE cycles apart
    localparam logic [TW-1:0] DLY_LOAD  = TW'((DLY_CYC > 0) ? DLY_CYC - 1 : 0);
    localparam logic [TW-1:0] RATE_LOAD = TW'((RATE_CYC > 0) ? RATE_CYC - 1 : 0);

    scan_state_t          state_q, state_d;
    logic [8*NKEYS-1:0]   snap_keys, prev_keys;
    logic [7:0]           snap_mod;
    logic [SW-1:0]        slot;
    logic                 new_pushed;
    logic [7:0]           rep_code;
    logic [15:0]          rep_data;
    logic                 rep_valid;
    logic [TW-1:0]        timer;
    logic                 repen, ovf, drop;
    logic                 rd_char_q, wr_ctrl_q;

    logic                 rd_char, wr_ctrl, pop, ctrl_we, flush;
    logic [7:0]           cur_code, cur_char;
    logic                 in_prev, rep_in_snap, slot_new;
    logic                 scan_push, scan_last, rep_active, rep_fire, rep_push;
    logic [15:0]          fifo_wdata, head;
    logic                 full, empty, ovf_set;
    logic [AW:0]          count;
    logic                 unused_ctrl_bits;

    assign rd_char = bus.usb_cs &  bus.R_W_n & (bus.reg_addr_i == REG_CHAR);
    assign wr_ctrl = bus.usb_cs & ~bus.R_W_n & (bus.reg_addr_i == REG_CTRL);
    assign pop     = rd_char & ~rd_char_q;
    assign ctrl_we = wr_ctrl & ~wr_ctrl_q;
    assign flush   = ctrl_we & bus.data_i[CTRL_FLUSH];
    assign unused_ctrl_bits = &{1'b0, bus.data_i[7:4]};

    always_comb begin
        cur_code    = snap_keys[8*int'(slot) +: 8];
        cur_char    = scancode2char(cur_code, snap_mod);
        in_prev     = 1'b0;
        rep_in_snap = 1'b0;
        for (int j = 0; j < NKEYS; j++) begin
            if (prev_keys[8*j +: 8] == cur_code) in_prev = 1'b1;
            if (snap_keys[8*j +: 8] == rep_code) rep_in_snap = 1'b1;
        end
        slot_new = (cur_code != 8'h00) & ~in_prev & (cur_char != 8'h00);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        scan_push = 1'b0;
        scan_last = (slot == SW'(NKEYS - 1));
        case (state_q)
            S_IDLE:   if (bus.report_i && bus.typ_i == TYP_KBD) state_d = S_SCAN;
            S_SCAN: begin
                scan_push = slot_new;
                if (scan_last) state_d = S_COMMIT;
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Repeat of the old key is held off between a new press and its commit
    assign rep_active = repen & rep_valid;
    assign rep_fire   = rep_active & ~new_pushed & (timer == '0);
    assign rep_push   = rep_fire & ~scan_push & ~flush;
    assign fifo_wdata = scan_push ? {cur_char, snap_mod} : rep_data;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            snap_keys  <= '0;
            prev_keys  <= '0;
            snap_mod   <= '0;
            slot       <= '0;
            new_pushed <= 1'b0;
            rep_code   <= '0;
            rep_data   <= '0;
            rep_valid  <= 1'b0;
            timer      <= '0;
            repen      <= 1'b1;
            ovf        <= 1'b0;
            drop       <= 1'b0;
            rd_char_q  <= 1'b0;
            wr_ctrl_q  <= 1'b0;
        end else begin
            rd_char_q <= rd_char;
            wr_ctrl_q <= wr_ctrl;
            if (ctrl_we) repen <= bus.data_i[CTRL_REPEN];
            if (ctrl_we && bus.data_i[CTRL_CLR_OVF])  ovf <= 1'b0;
            else if (ovf_set)                         ovf <= 1'b1;
            if (ctrl_we && bus.data_i[CTRL_CLR_DROP]) drop <= 1'b0;
            else if (bus.report_i && state_q != S_IDLE) drop <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (bus.report_i) begin
                        if (bus.typ_i == TYP_KBD) begin
                            snap_keys  <= bus.keys_i;
                            snap_mod   <= bus.key_modifiers_i;
                            slot       <= '0;
                            new_pushed <= 1'b0;
                        end else begin
                            prev_keys <= '0;
                            rep_valid <= 1'b0;
                        end
                    end
                end
                S_SCAN: begin
                    slot <= slot + SW'(1);
                    if (scan_push) begin
                        rep_code   <= cur_code;
                        rep_data   <= {cur_char, snap_mod};
                        rep_valid  <= 1'b1;
                        new_pushed <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    prev_keys  <= snap_keys;
                    new_pushed <= 1'b0;
                    if (!rep_in_snap) rep_valid <= 1'b0;
                end
                default: ;
            endcase

            if (state_q == S_COMMIT && new_pushed) begin
                timer <= DLY_LOAD;
            end else if (rep_active && !new_pushed) begin
                if (timer != '0)   timer <= timer - TW'(1);
                else if (rep_push) timer <= RATE_LOAD;
            end
        end
    end

    usb_kbd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (scan_push | rep_push),
        .pop     (pop),
        .flush   (flush),
        .wdata   (fifo_wdata),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf_set (ovf_set)
    );

    always_comb begin
        bus.data_o = 8'h00;
        case (bus.reg_addr_i)
            REG_STATUS: bus.data_o = {4'b0000, repen, ovf, full, ~empty};
            REG_CHAR:   bus.data_o = empty ? 8'h00 : head[15:8];
            REG_MOD:    bus.data_o = empty ? 8'h00 : head[7:0];
            REG_COUNT:  bus.data_o = 8'(count);
            REG_DROPS:  bus.data_o = {7'b0000000, drop};
            default:    bus.data_o = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_usb_kbd_buffer.sv
// tb/tb_usb_kbd_buffer.sv - scoreboard bench for usb_kbd_buffer
module tb_usb_kbd_buffer;
    import usb_hid_pkg::*;

    localparam int NKEYS = 6;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
        int         id;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_n_i;
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rd_id  = 0;

    always #5 clk_i = ~clk_i;

    usb_kbd_buffer_if #(.NKEYS(NKEYS)) bus ();

    usb_kbd_buffer #(
        .NKEYS(NKEYS), .DEPTH(8), .CLK_HZ(1000), .REP_DELAY_MS(5), .REP_RATE_MS(2)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (rst_n_i && bus.usb_cs && bus.R_W_n) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read addr=%02h got %02h expected none", bus.reg_addr_i, bus.data_o);
            end else begin
                e = sb_q.pop_front();
                if (bus.data_o !== e.exp) begin
                    errors++;
                    $display("FAIL read#%0d addr=%02h got %02h expected %02h", e.id, e.addr, bus.data_o, e.exp);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic expect_rd(input logic [7:0] a, input logic [7:0] e);
        sb_q.push_back('{addr: a, exp: e, id: rd_id});
        rd_id++;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        expect_rd(a, e);
        bus.usb_cs = 1'b1;
        bus.R_W_n = 1'b1;
        bus.reg_addr_i = a;
        cyc(1);
        bus.usb_cs = 1'b0;
        if (a == REG_CHAR) cyc(1);
    endtask

    task automatic wr(input logic [7:0] v);
        bus.usb_cs = 1'b1;
        bus.R_W_n = 1'b0;
        bus.reg_addr_i = REG_CTRL;
        bus.data_i = v;
        cyc(1);
        bus.usb_cs = 1'b0;
        bus.R_W_n = 1'b1;
    endtask

    task automatic report(input logic [1:0] t, input logic [7:0] m, input logic [8*NKEYS-1:0] k);
        bus.report_i = 1'b1;
        bus.typ_i = t;
        bus.key_modifiers_i = m;
        bus.keys_i = k;
        cyc(1);
        bus.report_i = 1'b0;
    endtask

    // Press, let the scan commit, then drop the keyboard before the repeat delay expires
    task automatic key_report(input logic [7:0] m, input logic [8*NKEYS-1:0] k);
        report(TYP_KBD, m, k);
        cyc(NKEYS + 1);
        report(TYP_MOUSE, 8'h00, '0);
    endtask

    initial begin
        rst_n_i = 1'b0;
        bus.report_i = 1'b0;
        bus.typ_i = TYP_NONE;
        bus.key_modifiers_i = 8'h00;
        bus.keys_i = '0;
        bus.usb_cs = 1'b0;
        bus.R_W_n = 1'b1;
        bus.reg_addr_i = 8'h00;
        bus.data_i = 8'h00;
        cyc(3);
        rst_n_i = 1'b1;
        cyc(1);

        rd(REG_STATUS, 8'h08);
        rd(REG_COUNT, 8'h00);
        rd(REG_CHAR, 8'h00);
        rd(REG_MOD, 8'h00);
        rd(REG_DROPS, 8'h00);
        rd(8'h07, 8'h00);

        // single 'a': push lands end of T+1
        report(TYP_KBD, 8'h00, 48'h04);
        rd(REG_STATUS, 8'h08);
        rd(REG_STATUS, 8'h09);
        rd(REG_COUNT, 8'h01);
        rd(REG_MOD, 8'h00);
        rd(REG_CHAR, 8'h61);
        rd(REG_COUNT, 8'h00);
        report(TYP_MOUSE, 8'h00, '0);
        rd(REG_STATUS, 8'h08);

        // three slots with left shift
        key_report(8'h02, 48'h060504);
        rd(REG_COUNT, 8'h03);
        for (int i = 0; i < 3; i++) begin
            rd(REG_MOD, 8'h02);
            rd(REG_CHAR, 8'h41 + 8'(i));
        end
        rd(REG_COUNT, 8'h00);

        // overflow: nine keys into eight entries
        for (int i = 0; i < 9; i++) key_report(8'h00, 48'(8'h04 + 8'(i)));
        rd(REG_STATUS, 8'h0f);
        rd(REG_COUNT, 8'h08);
        wr(8'h05);
        rd(REG_STATUS, 8'h0b);
        for (int i = 0; i < 8; i++) rd(REG_CHAR, 8'h61 + 8'(i));
        rd(REG_COUNT, 8'h00);
        rd(REG_CHAR, 8'h00);
        rd(REG_STATUS, 8'h08);

        // flush
        key_report(8'h00, 48'h05);
        rd(REG_COUNT, 8'h01);
        wr(8'h03);
        rd(REG_COUNT, 8'h00);
        rd(REG_STATUS, 8'h08);

        // second report during SCAN is dropped
        report(TYP_KBD, 8'h00, 48'h04);
        cyc(1);
        report(TYP_KBD, 8'h00, 48'h05);
        cyc(5);
        report(TYP_MOUSE, 8'h00, '0);
        rd(REG_DROPS, 8'h01);
        rd(REG_COUNT, 8'h01);
        rd(REG_CHAR, 8'h61);
        wr(8'h09);
        rd(REG_DROPS, 8'h00);
        rd(REG_COUNT, 8'h00);

        // read strobe held 4 cycles pops once; head moves to 'b' after the first cycle
        key_report(8'h00, 48'h0504);
        expect_rd(REG_CHAR, 8'h61);
        for (int i = 0; i < 3; i++) expect_rd(REG_CHAR, 8'h62);
        bus.usb_cs = 1'b1;
        bus.R_W_n = 1'b1;
        bus.reg_addr_i = REG_CHAR;
        cyc(4);
        bus.usb_cs = 1'b0;
        cyc(1);
        rd(REG_COUNT, 8'h01);
        rd(REG_CHAR, 8'h62);
        rd(REG_COUNT, 8'h00);
        rd(REG_CHAR, 8'h00);
        rd(REG_COUNT, 8'h00);

        // typematic: press at T, commit T+7, repeats at T+12, T+14, T+16
        report(TYP_KBD, 8'h00, 48'h04);
        cyc(8);
        report(TYP_KBD, 8'h00, 48'h04);
        cyc(2);
        rd(REG_COUNT, 8'h01);
        rd(REG_COUNT, 8'h02);
        cyc(3);
        report(TYP_MOUSE, 8'h00, '0);
        rd(REG_COUNT, 8'h04);
        cyc(20);
        rd(REG_COUNT, 8'h04);
        for (int i = 0; i < 4; i++) rd(REG_CHAR, 8'h61);
        rd(REG_COUNT, 8'h00);

        // clearing repen stops repeats
        report(TYP_KBD, 8'h00, 48'h04);
        cyc(1);
        wr(8'h00);
        cyc(20);
        rd(REG_COUNT, 8'h01);
        rd(REG_STATUS, 8'h01);
        report(TYP_MOUSE, 8'h00, '0);
        wr(8'h01);
        rd(REG_STATUS, 8'h09);
        rd(REG_CHAR, 8'h61);
        rd(REG_COUNT, 8'h00);

        cyc(2);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
